pipearch_write_arbiter: RTL and testbench

// Shares one fifobram write port between NUM_SRC write-forward producers for one instruction.
// op_start latches a burst length and burst count from regs[0]. Each burst is one round-robin

---
 rtl/pipearch_write_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_pipearch_write_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipearch_write_arbiter.sv
// Round-robin arbiter sharing one fifobram write port between NUM_SRC producers.
// One instruction is a number of bursts; each burst is one grant to one source.
module pipearch_write_arbiter #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 512
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               op_start,
    input  logic [31:0]                        regs [0:0],
    output logic                               op_done,
    output logic                               busy,
    input  logic [NUM_SRC-1:0]                 src_req,
    output logic [NUM_SRC-1:0]                 src_grant,
    input  logic [NUM_SRC-1:0]                 src_we,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0]      src_waddr,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]      src_wdata,
    input  logic [NUM_SRC-1:0]                 src_wfifobram,
    output logic                               wr_we,
    output logic [ADDR_WIDTH-1:0]              wr_waddr,
    output logic [DATA_WIDTH-1:0]              wr_wdata,
    output logic                               wr_wfifobram,
    output logic [$clog2(NUM_SRC)-1:0]         grant_id,
    output logic                               protocol_err
);

    localparam int unsigned IDW = $clog2(NUM_SRC);
    localparam int unsigned CW  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_BURST = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           lines_q, lines_d;
    logic [CW-1:0]           bursts_q, bursts_d;
    logic [CW-1:0]           line_cnt_q, line_cnt_d;
    logic [CW-1:0]           burst_cnt_q, burst_cnt_d;
    logic [IDW-1:0]          last_grant_q, last_grant_d;
    logic [IDW-1:0]          grant_id_q, grant_id_d;
    logic [NUM_SRC-1:0]      src_grant_q, src_grant_d;
    logic                    wr_we_q, wr_we_d;
    logic [ADDR_WIDTH-1:0]   wr_waddr_q, wr_waddr_d;
    logic [DATA_WIDTH-1:0]   wr_wdata_q, wr_wdata_d;
    logic                    wr_wfifobram_q, wr_wfifobram_d;
    logic                    op_done_q, op_done_d;
    logic                    busy_q, busy_d;
    logic                    perr_q, perr_d;

    logic [ADDR_WIDTH-1:0]   waddr_arr [NUM_SRC];
    logic [DATA_WIDTH-1:0]   wdata_arr [NUM_SRC];
    logic                    pick_found;
    logic [IDW-1:0]          pick_idx;
    logic [IDW-1:0]          cand;
    logic                    start_zero;
    logic                    beat;
    logic                    rogue;
    logic                    last_line;
    logic                    last_burst;

    // Unpack the flat per-source buses into indexable arrays.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign waddr_arr[i] = src_waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[i] = src_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign start_zero = (regs[0][15:0] == '0) || (regs[0][31:16] == '0);
    assign beat       = (state_q == ST_BURST) && src_we[grant_id_q];
    assign last_line  = (line_cnt_q == lines_q - CW'(1));
    assign last_burst = (burst_cnt_q == bursts_q - CW'(1));

    // Outside a burst every write strobe is illegal; inside, only the granted one is.
    always_comb begin : rogue_detect
        rogue = 1'b0;
        if (state_q == ST_BURST) begin
            rogue = |(src_we & ~src_grant_q);
        end else begin
            rogue = |src_we;
        end
    end

    // First requester strictly after the last winner, wrapping around.
    always_comb begin : rr_pick
        pick_found = 1'b0;
        pick_idx   = last_grant_q;
        cand       = last_grant_q;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            cand = IDW'((32'(last_grant_q) + k) % NUM_SRC);
            if (!pick_found && src_req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin : state_reg
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (op_start && !start_zero) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (pick_found) begin
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (beat && last_line) begin
                    state_d = last_burst ? ST_IDLE : ST_ARB;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin : output_logic
        lines_d        = lines_q;
        bursts_d       = bursts_q;
        line_cnt_d     = line_cnt_q;
        burst_cnt_d    = burst_cnt_q;
        last_grant_d   = last_grant_q;
        grant_id_d     = grant_id_q;
        src_grant_d    = src_grant_q;
        wr_we_d        = 1'b0;
        wr_waddr_d     = wr_waddr_q;
        wr_wdata_d     = wr_wdata_q;
        wr_wfifobram_d = wr_wfifobram_q;
        op_done_d      = 1'b0;
        perr_d         = perr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (op_start) begin
                    lines_d     = regs[0][15:0];
                    bursts_d    = regs[0][31:16];
                    line_cnt_d  = '0;
                    burst_cnt_d = '0;
                    perr_d      = 1'b0;
                    op_done_d   = start_zero;
                end
            end
            ST_ARB: begin
                if (pick_found) begin
                    src_grant_d = NUM_SRC'(1) << pick_idx;
                    grant_id_d  = pick_idx;
                end
            end
            ST_BURST: begin
                if (beat) begin
                    wr_we_d        = 1'b1;
                    wr_waddr_d     = waddr_arr[grant_id_q];
                    wr_wdata_d     = wdata_arr[grant_id_q];
                    wr_wfifobram_d = src_wfifobram[grant_id_q];
                    line_cnt_d     = line_cnt_q + CW'(1);
                    // Final beat of the burst releases the grant on the same edge.
                    if (last_line) begin
                        src_grant_d  = '0;
                        line_cnt_d   = '0;
                        last_grant_d = grant_id_q;
                        burst_cnt_d  = burst_cnt_q + CW'(1);
                        op_done_d    = last_burst;
                    end
                end
            end
            default: ;
        endcase

        if (rogue) begin
            perr_d = 1'b1;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin : data_reg
        if (!reset) begin
            lines_q        <= '0;
            bursts_q       <= '0;
            line_cnt_q     <= '0;
            burst_cnt_q    <= '0;
            last_grant_q   <= IDW'(NUM_SRC - 1);
            grant_id_q     <= '0;
            src_grant_q    <= '0;
            wr_we_q        <= 1'b0;
            wr_waddr_q     <= '0;
            wr_wdata_q     <= '0;
            wr_wfifobram_q <= 1'b0;
            op_done_q      <= 1'b0;
            busy_q         <= 1'b0;
            perr_q         <= 1'b0;
        end else begin
            lines_q        <= lines_d;
            bursts_q       <= bursts_d;
            line_cnt_q     <= line_cnt_d;
            burst_cnt_q    <= burst_cnt_d;
            last_grant_q   <= last_grant_d;
            grant_id_q     <= grant_id_d;
            src_grant_q    <= src_grant_d;
            wr_we_q        <= wr_we_d;
            wr_waddr_q     <= wr_waddr_d;
            wr_wdata_q     <= wr_wdata_d;
            wr_wfifobram_q <= wr_wfifobram_d;
            op_done_q      <= op_done_d;
            busy_q         <= busy_d;
            perr_q         <= perr_d;
        end
    end

    assign op_done      = op_done_q;
    assign busy         = busy_q;
    assign src_grant    = src_grant_q;
    assign wr_we        = wr_we_q;
    assign wr_waddr     = wr_waddr_q;
    assign wr_wdata     = wr_wdata_q;
    assign wr_wfifobram = wr_wfifobram_q;
    assign grant_id     = grant_id_q;
    assign protocol_err = perr_q;

    grant_onehot_a: assert property (@(posedge clk) disable iff (!reset) $onehot0(src_grant_q));

endmodule

// File: tb/tb_pipearch_write_arbiter.sv
// Randomized bench for pipearch_write_arbiter against a phase-level reference model.
`timescale 1ns/1ps
module tb_pipearch_write_arbiter;

    localparam int NUM_SRC = 4;
    localparam int AW      = 10;
    localparam int DW      = 512;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  op_start;
    logic [31:0]           regs [0:0];
    logic                  op_done;
    logic                  busy;
    logic [NUM_SRC-1:0]    src_req;
    logic [NUM_SRC-1:0]    src_grant;
    logic [NUM_SRC-1:0]    src_we;
    logic [NUM_SRC*AW-1:0] src_waddr;
    logic [NUM_SRC*DW-1:0] src_wdata;
    logic [NUM_SRC-1:0]    src_wfifobram;
    logic                  wr_we;
    logic [AW-1:0]         wr_waddr;
    logic [DW-1:0]         wr_wdata;
    logic                  wr_wfifobram;
    logic [1:0]            grant_id;
    logic                  protocol_err;

    logic [AW-1:0]         s_addr [NUM_SRC];
    logic [DW-1:0]         s_data [NUM_SRC];

    pipearch_write_arbiter #(
        .NUM_SRC   (NUM_SRC),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .op_start     (op_start),
        .regs         (regs),
        .op_done      (op_done),
        .busy         (busy),
        .src_req      (src_req),
        .src_grant    (src_grant),
        .src_we       (src_we),
        .src_waddr    (src_waddr),
        .src_wdata    (src_wdata),
        .src_wfifobram(src_wfifobram),
        .wr_we        (wr_we),
        .wr_waddr     (wr_waddr),
        .wr_wdata     (wr_wdata),
        .wr_wfifobram (wr_wfifobram),
        .grant_id     (grant_id),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_waddr[i*AW +: AW] = s_addr[i];
            src_wdata[i*DW +: DW] = s_data[i];
        end
    end

    // Reference model: instruction phase (0 idle, 1 waiting for grant, 2 in burst)
    int            m_phase, m_lines, m_bursts, m_beat, m_bidx, m_last, m_cur;
    logic          exp_we, exp_sel, exp_done, exp_busy, exp_perr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic [3:0]    exp_grant;
    logic [1:0]    exp_gid;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [NUM_SRC-1:0] req);
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (req[2'((last + k) % NUM_SRC)]) return (last + k) % NUM_SRC;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_lines = 0; m_bursts = 0; m_beat = 0; m_bidx = 0;
        m_last = NUM_SRC - 1; m_cur = 0;
        exp_we = 1'b0; exp_sel = 1'b0; exp_done = 1'b0; exp_busy = 1'b0; exp_perr = 1'b0;
        exp_addr = '0; exp_data = '0; exp_grant = '0; exp_gid = '0;
    endtask

    // Predict the effect of the coming clock edge given the inputs now driven.
    task automatic model_edge();
        bit rogue;
        int g;
        rogue    = 1'b0;
        exp_we   = 1'b0;
        exp_done = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_we[i] && !(m_phase == 2 && i == m_cur)) rogue = 1'b1;
        end
        case (m_phase)
            0: begin
                if (op_start) begin
                    exp_perr = 1'b0;
                    m_lines  = int'(regs[0][15:0]);
                    m_bursts = int'(regs[0][31:16]);
                    m_beat   = 0;
                    m_bidx   = 0;
                    if (m_lines == 0 || m_bursts == 0) exp_done = 1'b1;
                    else m_phase = 1;
                end
            end
            1: begin
                g = rr_pick(m_last, src_req);
                if (g >= 0) begin
                    m_cur     = g;
                    exp_grant = 4'(1) << g;
                    exp_gid   = 2'(g);
                    m_phase   = 2;
                end
            end
            2: begin
                if (src_we[2'(m_cur)]) begin
                    exp_we   = 1'b1;
                    exp_addr = s_addr[2'(m_cur)];
                    exp_data = s_data[2'(m_cur)];
                    exp_sel  = src_wfifobram[2'(m_cur)];
                    m_beat++;
                    if (m_beat == m_lines) begin
                        exp_grant = '0;
                        m_last    = m_cur;
                        m_beat    = 0;
                        m_bidx++;
                        if (m_bidx == m_bursts) begin
                            m_phase  = 0;
                            exp_done = 1'b1;
                        end else begin
                            m_phase = 1;
                        end
                    end
                end
            end
            default: ;
        endcase
        if (rogue) exp_perr = 1'b1;
        exp_busy = (m_phase != 0);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check("wr_we", DW'(wr_we), DW'(exp_we));
        if (exp_we) begin
            check("wr_waddr", DW'(wr_waddr), DW'(exp_addr));
            check("wr_wdata", wr_wdata, exp_data);
            check("wr_wfifobram", DW'(wr_wfifobram), DW'(exp_sel));
        end
        check("op_done", DW'(op_done), DW'(exp_done));
        check("busy", DW'(busy), DW'(exp_busy));
        check("src_grant", DW'(src_grant), DW'(exp_grant));
        check("grant_id", DW'(grant_id), DW'(exp_gid));
        check("protocol_err", DW'(protocol_err), DW'(exp_perr));
    endtask

    task automatic quiet_inputs();
        op_start = 1'b0;
        src_req  = '0;
        src_we   = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr_we"}, DW'(wr_we), '0);
        check({tag, "_wr_waddr"}, DW'(wr_waddr), '0);
        check({tag, "_wr_wdata"}, wr_wdata, '0);
        check({tag, "_wr_sel"}, DW'(wr_wfifobram), '0);
        check({tag, "_op_done"}, DW'(op_done), '0);
        check({tag, "_busy"}, DW'(busy), '0);
        check({tag, "_grant"}, DW'(src_grant), '0);
        check({tag, "_grant_id"}, DW'(grant_id), '0);
        check({tag, "_perr"}, DW'(protocol_err), '0);
    endtask

    task automatic do_reset();
        quiet_inputs();
        reset = 1'b0;
        #1;
        check_zero("rst");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // One instruction: req_pat==0 means random requests; dense forces a beat every burst cycle.
    task automatic run_op(input logic [31:0] r, input logic [3:0] req_pat,
                          input bit dense, input bit rogue, input bit seq);
        int budget;
        int addr_seq;
        addr_seq = 0;
        quiet_inputs();
        op_start = 1'b1;
        regs[0]  = r;
        cycle();
        op_start = 1'b0;
        budget   = 400;
        while (m_phase != 0 && budget > 0) begin
            budget--;
            src_we   = '0;
            src_req  = (req_pat != 0) ? req_pat : 4'($urandom);
            op_start = ($urandom_range(0, 15) == 0);
            if (op_start) regs[0] = $urandom;
            for (int i = 0; i < NUM_SRC; i++) begin
                s_addr[i]        = AW'($urandom);
                s_data[i]        = rand_data();
                src_wfifobram[i] = 1'($urandom);
            end
            if (m_phase == 2) begin
                if (dense || $urandom_range(0, 3) != 0) begin
                    src_we[2'(m_cur)] = 1'b1;
                    if (seq) begin
                        s_addr[2'(m_cur)] = AW'(addr_seq);
                        addr_seq++;
                    end
                end
                if (rogue) src_we[2'((m_cur + 1) % NUM_SRC)] = 1'b1;
            end
            cycle();
        end
        quiet_inputs();
        check("op_complete", DW'(32'(m_phase)), '0);
    endtask

    initial begin
        reset    = 1'b0;
        regs[0]  = '0;
        src_wfifobram = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s_addr[i] = '0;
            s_data[i] = '0;
        end
        quiet_inputs();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Single burst of four sequential addresses from source 0
        run_op(32'h0001_0004, 4'b0001, 1'b1, 1'b0, 1'b1);
        cycle();

        // Four two-line bursts with every source requesting, from a fresh reset
        do_reset();
        run_op(32'h0004_0002, 4'b1111, 1'b1, 1'b0, 1'b0);
        cycle();

        // Leave last grant at 2, then 1001 must go 3 then wrap to 0
        run_op(32'h0001_0001, 4'b0100, 1'b1, 1'b0, 1'b0);
        run_op(32'h0002_0001, 4'b1001, 1'b1, 1'b0, 1'b0);
        cycle();

        // Zero-length instruction completes immediately
        run_op(32'h0003_0000, 4'b0001, 1'b1, 1'b0, 1'b0);
        cycle();
        cycle();

        // Source 1 strobes while source 0 owns the port; error must stay sticky
        do_reset();
        run_op(32'h0001_0004, 4'b0001, 1'b1, 1'b1, 1'b0);
        cycle();
        cycle();

        // Reset lands on beat 2 of 4
        do_reset();
        op_start = 1'b1;
        regs[0]  = 32'h0001_0004;
        src_req  = 4'b0001;
        cycle();
        op_start = 1'b0;
        cycle();
        src_we   = 4'b0001;
        cycle();
        src_we   = 4'b0001;
        #2;
        reset    = 1'b0;
        #1;
        check_zero("mid_rst");
        @(negedge clk);
        check_zero("mid_rst_hold");
        quiet_inputs();
        reset = 1'b1;
        model_reset();
        run_op(32'h0001_0001, 4'b1111, 1'b1, 1'b0, 1'b0);
        cycle();

        // Randomized instructions with idle-time strobes sprinkled in
        for (int n = 0; n < 30; n++) begin
            logic [15:0] ln, bs;
            ln = 16'($urandom_range(1, 4));
            bs = 16'($urandom_range(1, 4));
            if ($urandom_range(0, 7) == 0) ln = '0;
            if ($urandom_range(0, 7) == 0) bs = '0;
            run_op({bs, ln}, ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'b0000,
                   1'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
            if ($urandom_range(0, 3) == 0) src_we = 4'($urandom);
            cycle();
            quiet_inputs();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
